modport_slave: RTL and testbench
================================

// Module: modport_slave
// PURPOSE
// - APB3-style zero-wait-state slave holding a small register file.
// - Serves as the frontdoor target of the register-abstraction (RAL) environment.
// - Sits directly behind the APB bus interface (drv/mon clocking, sampled at posedge PCLK).
// - Provides RW control/data registers plus a read-only ID word for frontdoor read/write checks.
// PARAMETERS
// - ADDR_W    32            APB address width
// - DATA_W    32            APB data width
// - ID_VALUE  32'h4D50_0001 constant returned by the ID register
// PORTS
// - PCLK     in   1       bus clock; all state updates on its rising edge
// - PRESET   in   1       synchronous, active-high reset (one clock, sampled on PCLK)
// - PSEL     in   1       slave select
// - PENABLE  in   1       access-phase strobe
// - PWRITE   in   1       1 = write, 0 = read
// - PADDR    in   ADDR_W  byte address
// - PWDATA   in   DATA_W  write data
// - PRDATA   out  DATA_W  read data, registered
// BEHAVIOUR
// - Register map (word aligned; PADDR[1:0] must be 0):
//   - 0x00 CTRL: bits [3:0] RW; [31:4] read 0, writes ignored; reset 0
//   - 0x04 REG1: [31:0] RW, reset 0
//   - 0x08 REG2: [31:0] RW, reset 0
//   - 0x0C REG3: [31:0] RW, reset 0
//   - 0x10 ID: RO, reads ID_VALUE, writes ignored
// - Any other address, including misaligned addresses and PADDR[31:5] != 0, is unmapped:
//   - reads return 0
//   - writes have no effect
// - Reset (PRESET = 1 at a posedge):
//   - all registers = 0; PRDATA = 0; FSM = IDLE
//   - this overrides any transfer in flight; a write in its ACCESS cycle is dropped
// - Phase FSM (IDLE, SETUP, ACCESS), evaluated at each posedge:
//   - IDLE   -> SETUP  when PSEL & !PENABLE; otherwise stay IDLE
//   - SETUP  -> ACCESS when PSEL & PENABLE; otherwise -> IDLE (aborted transfer, no effect)
//   - ACCESS -> SETUP  when PSEL & !PENABLE (back-to-back transfer); otherwise -> IDLE
// - Write:
//   - committed at the posedge where FSM = SETUP and PSEL & PENABLE & PWRITE
//   - the register holds the new value from the following cycle (1-cycle latency)
// - Read:
//   - PRDATA is loaded at the posedge where FSM = IDLE or ACCESS and PSEL & !PENABLE & !PWRITE
//     (the end of the SETUP phase)
//   - PRDATA is therefore stable for the whole ACCESS cycle
//   - PRDATA holds its value at all other times
// - PENABLE high without a preceding SETUP cycle is a protocol violation: ignored, no write.
// - No wait states: every transfer completes in exactly 2 cycles. No PREADY or PSLVERR.
// - Read-after-write to the same register on consecutive transfers returns the new value.
// STRUCTURE
// - Package modport_pkg:
//   - address constants ADDR_CTRL, ADDR_REG1, ADDR_REG2, ADDR_REG3, ADDR_ID
//   - CTRL_W = 4
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e
// - Top: the APB phase FSM plus address decode.
// - One sub-module, modport_regfile: holds the storage, takes wr_en/addr/wdata, returns the
//   combinational rdata mux.
// TESTING
// - Reset check: PRESET = 1 for 1 cycle, then read 0x00, 0x04, 0x08, 0x0C -> each 0;
//   read 0x10 -> 0x4D500001.
// - Write/readback: write 0x04 = 0xDEADBEEF, 0x08 = 0x12345678, 0x0C = 0xFFFFFFFF; read each
//   -> same values, with PRDATA valid in the ACCESS cycle.
// - CTRL width: write 0x00 = 0xFFFFFFFF -> read 0x0000000F. ID write: write 0x10 = 0 -> still
//   reads 0x4D500001.
// - Unmapped/misaligned: write 0x14 = 0xAAAA5555, write 0x06 = 1 -> all registers unchanged;
//   read 0x14 -> 0.
// - Aborted/illegal: SETUP with PSEL dropped before ACCESS, and PENABLE without a SETUP
//   cycle -> no register change.
// - Reset mid-write: assert PRESET in the ACCESS cycle of a write of 0x55 to 0x04 -> REG1 = 0.

Source files
------------

// File: rtl/modport_pkg.sv
// modport_pkg: register map addresses, CTRL width, APB phase and register-select enums
package modport_pkg;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] ADDR_REG1 = 32'h0000_0004;
  localparam logic [31:0] ADDR_REG2 = 32'h0000_0008;
  localparam logic [31:0] ADDR_REG3 = 32'h0000_000C;
  localparam logic [31:0] ADDR_ID   = 32'h0000_0010;
  localparam int CTRL_W = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  typedef enum logic [2:0] {SEL_CTRL, SEL_REG1, SEL_REG2, SEL_REG3, SEL_ID, SEL_NONE} reg_sel_e;
endpackage

// File: rtl/modport_regfile.sv
// modport_regfile: CTRL/REG1-3 storage plus RO ID; ports clk, rst, wr_en, sel, wdata in; rdata (comb) out
module modport_regfile
  import modport_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h4D50_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  reg_sel_e          sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d, reg3_q, reg3_d;

  always_comb begin
    ctrl_d = wr_en && sel == SEL_CTRL ? wdata[CTRL_W-1:0] : ctrl_q;
    reg1_d = wr_en && sel == SEL_REG1 ? wdata : reg1_q;
    reg2_d = wr_en && sel == SEL_REG2 ? wdata : reg2_q;
    reg3_d = wr_en && sel == SEL_REG3 ? wdata : reg3_q;
    rdata  = sel == SEL_CTRL ? {{(DATA_W-CTRL_W){1'b0}}, ctrl_q} :
             sel == SEL_REG1 ? reg1_q :
             sel == SEL_REG2 ? reg2_q :
             sel == SEL_REG3 ? reg3_q :
             sel == SEL_ID   ? ID_VALUE : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      reg3_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      reg3_q <= reg3_d;
    end
  end
endmodule

// File: rtl/modport_slave.sv
// modport_slave: zero-wait APB3 slave; PCLK/PRESET, PSEL/PENABLE/PWRITE/PADDR/PWDATA in, registered PRDATA out
module modport_slave
  import modport_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'h4D50_0001
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA
);
  apb_state_e state_q, state_d;
  reg_sel_e sel;
  logic [DATA_W-1:0] prdata_q, prdata_d, rdata;
  logic setup_req, access_req, wr_en;

  always_comb begin
    sel = PADDR == ADDR_W'(ADDR_CTRL) ? SEL_CTRL :
          PADDR == ADDR_W'(ADDR_REG1) ? SEL_REG1 :
          PADDR == ADDR_W'(ADDR_REG2) ? SEL_REG2 :
          PADDR == ADDR_W'(ADDR_REG3) ? SEL_REG3 :
          PADDR == ADDR_W'(ADDR_ID)   ? SEL_ID   : SEL_NONE;
    setup_req  = PSEL && !PENABLE;
    access_req = PSEL && PENABLE;
    state_d  = state_q == SETUP ? (access_req ? ACCESS : IDLE) : (setup_req ? SETUP : IDLE);
    wr_en    = state_q == SETUP && access_req && PWRITE;
    prdata_d = state_q != SETUP && setup_req && !PWRITE ? rdata : prdata_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
    end
  end

  modport_regfile #(.DATA_W(DATA_W), .ID_VALUE(ID_VALUE)) u_regfile (
    .clk  (PCLK),
    .rst  (PRESET),
    .wr_en(wr_en),
    .sel  (sel),
    .wdata(PWDATA),
    .rdata(rdata)
  );

  assign PRDATA = prdata_q;
endmodule

// File: tb/tb_modport_slave.sv
// tb_modport_slave: directed APB frontdoor checks of modport_slave
module tb_modport_slave;
  localparam logic [31:0] ID = 32'h4D50_0001;
  logic        PCLK = 0, PRESET = 1, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA, rd;
  int n_chk = 0, n_err = 0;

  modport_slave dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
    PSEL = 0;
    PENABLE = 0;
    PWRITE = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1;
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1;
    chk(tag, PRDATA, exp);
  endtask

  initial begin
    repeat (2) @(negedge PCLK);
    PRESET = 0;
    chk("rst_prdata", PRDATA, 32'h0);
    rdc("rst_ctrl", 32'h00, 32'h0);
    rdc("rst_reg1", 32'h04, 32'h0);
    rdc("rst_reg2", 32'h08, 32'h0);
    rdc("rst_reg3", 32'h0C, 32'h0);
    rdc("rst_id", 32'h10, ID);
    wr(32'h04, 32'hDEADBEEF);
    wr(32'h08, 32'h12345678);
    wr(32'h0C, 32'hFFFFFFFF);
    rdc("rb_reg1", 32'h04, 32'hDEADBEEF);
    rdc("rb_reg2", 32'h08, 32'h12345678);
    rdc("rb_reg3", 32'h0C, 32'hFFFFFFFF);
    idle();
    chk("prdata_hold", PRDATA, 32'hFFFFFFFF);
    wr(32'h00, 32'hFFFFFFFF);
    rdc("ctrl_width", 32'h00, 32'h0000000F);
    wr(32'h10, 32'h0);
    rdc("id_ro", 32'h10, ID);
    wr(32'h0C, 32'h0BAD_F00D);
    rdc("raw_reg3", 32'h0C, 32'h0BAD_F00D);
    wr(32'h14, 32'hAAAA5555);
    wr(32'h06, 32'h1);
    wr(32'h24, 32'h2);
    rdc("unmap_rd", 32'h14, 32'h0);
    rdc("misalign_rd", 32'h05, 32'h0);
    rdc("upper_rd", 32'h24, 32'h0);
    rdc("unmap_reg1", 32'h04, 32'hDEADBEEF);
    rdc("unmap_ctrl", 32'h00, 32'h0000000F);
    rdc("unmap_reg2", 32'h08, 32'h12345678);
    idle();
    @(negedge PCLK);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h08; PWDATA = 32'h1;
    @(negedge PCLK);
    PSEL = 0; PENABLE = 1;
    idle();
    @(negedge PCLK);
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h08; PWDATA = 32'h2;
    idle();
    rdc("abort_reg2", 32'h08, 32'h12345678);
    wr(32'h04, 32'h55);
    PRESET = 1;
    @(negedge PCLK);
    PRESET = 0;
    PSEL = 0; PENABLE = 0; PWRITE = 0;
    chk("midrst_prdata", PRDATA, 32'h0);
    rdc("midrst_reg1", 32'h04, 32'h0);
    rdc("midrst_reg2", 32'h08, 32'h0);
    rdc("midrst_ctrl", 32'h00, 32'h0);
    rdc("midrst_id", 32'h10, ID);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
